// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared 8259-style definitions: IR count, ID width, acknowledge-sequence state encoding.
package interrupt_ack_sequencer_pkg;

   localparam int IR_COUNT = 8;
   localparam int IR_ID_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ACK1    = 2'd2,
      ST_ACK2    = 2'd3
   } ack_state_e;

   // Isolates the lowest-index (highest-priority) set bit.
   function automatic logic [IR_COUNT-1:0] lowest_set(input logic [IR_COUNT-1:0] v);
      return v & (~v + 1'b1);
   endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Fixed-priority resolver, IR0 highest; purely combinational, no flow control.
module priority_resolver_8
   import interrupt_ack_sequencer_pkg::*;
(
   input  logic [IR_COUNT-1:0] eligible,
   output logic [IR_ID_W-1:0]  id,
   output logic                valid
);

   always_comb begin
      id    = '0;
      valid = 1'b0;
      // Scan downward so the last hit, the lowest index, wins.
      for (int n = IR_COUNT - 1; n >= 0; n--) begin
         if (eligible[n]) begin
            id    = IR_ID_W'(n);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Two-INTA acknowledge sequencer: raises int_out the cycle after a request is eligible,
// returns the vector on the second INTA fall; INTA edges outside their state are ignored.
module interrupt_ack_sequencer
   import interrupt_ack_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [IR_COUNT-1:0] interrupt_req_reg,
   input  logic [IR_COUNT-1:0] interrupt_mask,
   input  logic [4:0]          vector_base,
   input  logic                auto_eoi,
   input  logic                eoi_cmd,
   input  logic                inta_n,
   output logic                int_out,
   output logic [IR_COUNT-1:0] clear_ir_line,
   output logic [IR_COUNT-1:0] in_service_reg,
   output logic [7:0]          vector_out,
   output logic                vector_oe
);

   ack_state_e          state_q, state_d;
   logic                inta_n_d_q;
   logic                int_out_q, int_out_d;
   logic [IR_COUNT-1:0] clear_q, clear_d;
   logic [IR_COUNT-1:0] isr_q, isr_d;
   logic [7:0]          vec_q, vec_d;
   logic                oe_q, oe_d;
   logic [IR_ID_W-1:0]  irq_id_q, irq_id_d;
   logic                spur_q, spur_d;

   logic [IR_COUNT-1:0] eligible;
   logic [IR_ID_W-1:0]  win_id;
   logic                win_vld;
   logic                inta_fall, inta_rise;
   logic [IR_COUNT-1:0] isr_set, auto_clr, eoi_clr;

   assign inta_fall = inta_n_d_q & ~inta_n;
   assign inta_rise = ~inta_n_d_q & inta_n;

   // Fully nested: any in-service level blocks itself and everything below it.
   always_comb begin
      logic blocked;
      eligible = '0;
      blocked  = 1'b0;
      for (int n = 0; n < IR_COUNT; n++) begin
         blocked     = blocked | isr_q[n];
         eligible[n] = interrupt_req_reg[n] & ~interrupt_mask[n] & ~blocked;
      end
   end

   priority_resolver_8 u_resolver (
      .eligible (eligible),
      .id       (win_id),
      .valid    (win_vld)
   );

   always_comb begin
      state_d   = state_q;
      int_out_d = int_out_q;
      clear_d   = '0;
      vec_d     = vec_q;
      oe_d      = oe_q;
      irq_id_d  = irq_id_q;
      spur_d    = spur_q;
      isr_set   = '0;
      auto_clr  = '0;

      case (state_q)
         ST_IDLE: begin
            int_out_d = 1'b0;
            if (|eligible) begin
               state_d   = ST_PENDING;
               int_out_d = 1'b1;
            end
         end
         ST_PENDING: begin
            int_out_d = 1'b1;
            if (inta_fall) begin
               state_d   = ST_ACK1;
               int_out_d = 1'b0;
               if (win_vld) begin
                  irq_id_d = win_id;
                  isr_set  = IR_COUNT'(1) << win_id;
                  clear_d  = IR_COUNT'(1) << win_id;
                  spur_d   = 1'b0;
               end else begin
                  // Request vanished before the CPU acknowledged: hand out IR7.
                  irq_id_d = IR_ID_W'(IR_COUNT - 1);
                  spur_d   = 1'b1;
               end
            end
         end
         ST_ACK1: begin
            if (inta_fall) begin
               state_d = ST_ACK2;
               vec_d   = {vector_base, irq_id_q};
               oe_d    = 1'b1;
            end
         end
         ST_ACK2: begin
            if (inta_rise) begin
               state_d = ST_IDLE;
               oe_d    = 1'b0;
               if (auto_eoi && !spur_q) auto_clr = IR_COUNT'(1) << irq_id_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // EOI looks at the pre-set ISR; clears are merged so a shared bit clears once.
      eoi_clr = eoi_cmd ? lowest_set(isr_q) : '0;
      isr_d   = (isr_q & ~(eoi_clr | auto_clr)) | isr_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         inta_n_d_q <= 1'b1;
         int_out_q  <= 1'b0;
         clear_q    <= '0;
         isr_q      <= '0;
         vec_q      <= '0;
         oe_q       <= 1'b0;
         irq_id_q   <= '0;
         spur_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         inta_n_d_q <= inta_n;
         int_out_q  <= int_out_d;
         clear_q    <= clear_d;
         isr_q      <= isr_d;
         vec_q      <= vec_d;
         oe_q       <= oe_d;
         irq_id_q   <= irq_id_d;
         spur_q     <= spur_d;
      end
   end

   assign int_out        = int_out_q;
   assign clear_ir_line  = clear_q;
   assign in_service_reg = isr_q;
   assign vector_out     = vec_q;
   assign vector_oe      = oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed plus randomized bench for the acknowledge sequencer against a priority/ISR model.
module tb_interrupt_ack_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] irr;
   logic [7:0] mask;
   logic [4:0] base;
   logic       auto_eoi;
   logic       eoi_cmd;
   logic       inta_n;
   logic       int_out;
   logic [7:0] clear_ir_line;
   logic [7:0] in_service_reg;
   logic [7:0] vector_out;
   logic       vector_oe;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] isr_m  = 8'h00;
   bit         raised = 1'b0;

   always #5 clk = ~clk;

   interrupt_ack_sequencer dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .interrupt_req_reg (irr),
      .interrupt_mask    (mask),
      .vector_base       (base),
      .auto_eoi          (auto_eoi),
      .eoi_cmd           (eoi_cmd),
      .inta_n            (inta_n),
      .int_out           (int_out),
      .clear_ir_line     (clear_ir_line),
      .in_service_reg    (in_service_reg),
      .vector_out        (vector_out),
      .vector_oe         (vector_oe)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scan from IR0 down; the first level already in service stops everything beneath it.
   function automatic int winner(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s);
      for (int n = 0; n < 8; n++) begin
         if (s[n]) return -1;
         if (r[n] && !m[n]) return n;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock with no INTA activity, optionally carrying a non-specific EOI.
   task automatic plain_tick(input bit eoi, input string tag);
      int w;
      w       = winner(irr, mask, isr_m);
      eoi_cmd = eoi;
      tick();
      eoi_cmd = 1'b0;
      if (!raised && w >= 0) raised = 1'b1;
      if (eoi) isr_m = isr_m & (isr_m - 8'd1);
      chk({tag, "_int"}, int_out, raised);
      chk({tag, "_isr"}, in_service_reg, isr_m);
      chk({tag, "_clr"}, clear_ir_line, 0);
   endtask

   // Full two-pulse INTA handshake; eoi1 lands on INTA#1 fall, eoi2 on INTA#2 rise.
   task automatic ack(input string tag, input bit eoi1, input bit eoi2);
      int         w;
      logic [7:0] oh;
      logic [2:0] id;
      bit         spur;
      w    = winner(irr, mask, isr_m);
      spur = (w < 0);
      oh   = spur ? 8'h00 : (8'd1 << w);
      id   = spur ? 3'd7 : w[2:0];

      inta_n = 1'b0; eoi_cmd = eoi1;
      tick();
      eoi_cmd = 1'b0;
      if (eoi1) isr_m = isr_m & (isr_m - 8'd1);
      isr_m  = isr_m | oh;
      raised = 1'b0;
      chk({tag, "_a1_clr"}, clear_ir_line, oh);
      chk({tag, "_a1_int"}, int_out, 0);
      chk({tag, "_a1_isr"}, in_service_reg, isr_m);
      chk({tag, "_a1_oe"}, vector_oe, 0);

      irr = irr & ~oh; inta_n = 1'b1;
      tick();
      chk({tag, "_gap_clr"}, clear_ir_line, 0);
      chk({tag, "_gap_oe"}, vector_oe, 0);

      inta_n = 1'b0;
      tick();
      chk({tag, "_a2_oe"}, vector_oe, 1);
      chk({tag, "_a2_vec"}, vector_out, {base, id});
      chk({tag, "_a2_clr"}, clear_ir_line, 0);

      inta_n = 1'b1; eoi_cmd = eoi2;
      tick();
      eoi_cmd = 1'b0;
      if (eoi2) isr_m = isr_m & (isr_m - 8'd1);
      if (auto_eoi && !spur) isr_m = isr_m & ~oh;
      chk({tag, "_end_oe"}, vector_oe, 0);
      chk({tag, "_end_isr"}, in_service_reg, isr_m);
      chk({tag, "_end_int"}, int_out, 0);
   endtask

   initial begin
      reset_n = 1'b0; irr = 8'h00; mask = 8'h00; base = 5'h08;
      auto_eoi = 1'b0; eoi_cmd = 1'b0; inta_n = 1'b1;
      tick(); tick();
      chk("rst_int", int_out, 0);
      chk("rst_clr", clear_ir_line, 0);
      chk("rst_isr", in_service_reg, 0);
      chk("rst_vec", vector_out, 0);
      chk("rst_oe", vector_oe, 0);
      reset_n = 1'b1;

      // Single request on IR5, base 0x08.
      irr = 8'h20;
      plain_tick(1'b0, "r34");
      ack("r34", 1'b0, 1'b0);
      chk("r34_vec45", vector_out, 8'h45);
      chk("r34_isr20", in_service_reg, 8'h20);
      plain_tick(1'b1, "r34_eoi");

      // Two requests: IR1 first, IR3 held off until EOI.
      irr = 8'h0A;
      plain_tick(1'b0, "r35");
      ack("r35_ir1", 1'b0, 1'b0);
      plain_tick(1'b0, "r35_blk");
      plain_tick(1'b0, "r35_blk");
      plain_tick(1'b1, "r35_eoi");
      plain_tick(1'b0, "r35_ir3req");
      chk("r35_int_up", int_out, 1);
      ack("r35_ir3", 1'b0, 1'b0);
      plain_tick(1'b1, "r35_eoi3");

      // ISR bit 2 blocks IR4 until EOI.
      irr = 8'h04;
      plain_tick(1'b0, "r36_set");
      ack("r36_ir2", 1'b0, 1'b0);
      chk("r36_isr04", in_service_reg, 8'h04);
      irr = 8'h10;
      plain_tick(1'b0, "r36_blk");
      plain_tick(1'b0, "r36_blk");
      chk("r36_int_low", int_out, 0);
      plain_tick(1'b1, "r36_eoi");
      plain_tick(1'b0, "r36_req");
      chk("r36_int_up", int_out, 1);
      ack("r36_ir4", 1'b0, 1'b0);
      plain_tick(1'b1, "r36_eoi4");

      // Spurious: request withdrawn before INTA#1.
      irr = 8'h01;
      plain_tick(1'b0, "r37");
      irr = 8'h00;
      ack("r37_spur", 1'b0, 1'b0);
      chk("r37_vec", vector_out, {5'h08, 3'd7});
      chk("r37_isr", in_service_reg, 8'h00);

      // Auto-EOI.
      auto_eoi = 1'b1; irr = 8'h40;
      plain_tick(1'b0, "r38");
      ack("r38_auto", 1'b0, 1'b0);
      chk("r38_isr0", in_service_reg, 8'h00);
      auto_eoi = 1'b0;

      // EOI coinciding with an ISR set, then with an auto-EOI clear on the same bit.
      irr = 8'h20;
      plain_tick(1'b0, "coin_a");
      ack("coin_a", 1'b0, 1'b0);
      irr = 8'h02;
      plain_tick(1'b0, "coin_b");
      ack("coin_set", 1'b1, 1'b0);
      chk("coin_set_isr", in_service_reg, 8'h02);
      auto_eoi = 1'b1; irr = 8'h01;
      plain_tick(1'b0, "coin_c");
      ack("coin_auto", 1'b0, 1'b1);
      chk("coin_auto_isr", in_service_reg, 8'h02);
      auto_eoi = 1'b0;
      plain_tick(1'b1, "coin_eoi");

      for (int k = 0; k < 60; k++) begin
         bit e1, e2;
         irr      = 8'($urandom_range(0, 255));
         mask     = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
         base     = 5'($urandom_range(0, 31));
         auto_eoi = 1'($urandom_range(0, 1));
         plain_tick(1'b0, "rnd");
         if (raised) begin
            if ($urandom_range(0, 5) == 0) irr = 8'h00;
            e1 = 1'($urandom_range(0, 3) == 0);
            e2 = 1'($urandom_range(0, 3) == 0);
            ack("rnd_ack", e1, e2);
         end
         if ($urandom_range(0, 1) == 1) plain_tick(1'b1, "rnd_eoi");
      end

      // Reset while in ACK1 with a clear pulse in flight.
      while (raised) ack("pre_rst", 1'b0, 1'b0);
      mask = 8'h00; auto_eoi = 1'b0; base = 5'h1F;
      irr = 8'h80;
      plain_tick(1'b0, "r39_req");
      ack("r39_vecset", 1'b0, 1'b0);
      plain_tick(1'b1, "r39_eoi");
      irr = 8'h04;
      plain_tick(1'b0, "r39_req2");
      inta_n = 1'b0;
      tick();
      chk("r39_pulse", clear_ir_line, 8'h04);
      #2;
      reset_n = 1'b0;
      #1;
      chk("r39_async_int", int_out, 0);
      chk("r39_async_clr", clear_ir_line, 0);
      chk("r39_async_isr", in_service_reg, 0);
      chk("r39_async_vec", vector_out, 0);
      chk("r39_async_oe", vector_oe, 0);
      inta_n = 1'b1; irr = 8'h00;
      tick(); tick();
      chk("r39_hold_clr", clear_ir_line, 0);
      reset_n = 1'b1;
      isr_m = 8'h00; raised = 1'b0;
      plain_tick(1'b0, "r39_idle");
      irr = 8'h04;
      plain_tick(1'b0, "r39_restart");
      chk("r39_int_up", int_out, 1);
      ack("r39_ack", 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_ack_sequencer.md
INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 SHALL have no parameters; the IR count is fixed at 8 and IR0 has the highest priority.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port interrupt_req_reg, input, 8 bits: request bits from the interrupt request register.
REQ-005 SHALL have port interrupt_mask, input, 8 bits: a set bit masks that IR.
REQ-006 SHALL have port vector_base, input, 5 bits: vector bits T7..T3.
REQ-007 SHALL have port auto_eoi, input, 1 bit: when 1, the ISR bit clears automatically at the end of the second INTA.
REQ-008 SHALL have port eoi_cmd, input, 1 bit: one-cycle non-specific EOI pulse.
REQ-009 SHALL have port inta_n, input, 1 bit: CPU acknowledge, active-low, synchronous to clk.
REQ-010 SHALL have port int_out, output, 1 bit: interrupt request to the CPU.
REQ-011 SHALL have port clear_ir_line, output, 8 bits: one-hot, one-cycle clear pulse back to the request register.
REQ-012 SHALL have port in_service_reg, output, 8 bits: the ISR.
REQ-013 SHALL have port vector_out, output, 8 bits: the interrupt vector.
REQ-014 SHALL have port vector_oe, output, 1 bit: vector_out valid/drive enable.

Function
REQ-015 SHALL register inta_n into inta_n_d each cycle; an INTA fall is inta_n_d=1 and inta_n=0; an INTA rise is inta_n_d=0 and inta_n=1.
REQ-016 SHALL form eligible[n] = interrupt_req_reg[n] & ~interrupt_mask[n] & (in_service_reg[n:0]==0), so fully nested requests at equal or lower priority are blocked.
REQ-017 SHALL resolve the winner as the lowest-index set bit of eligible, combinationally.
REQ-018 SHALL implement states IDLE, PENDING, ACK1 and ACK2, encoded in 2 bits.
REQ-019 IDLE: if eligible is nonzero, SHALL go to PENDING and set int_out=1 on the same clock edge.
REQ-020 PENDING: int_out SHALL hold at 1 even if eligible drops to zero; on an INTA fall SHALL latch the winner into irq_id, set in_service_reg[irq_id], pulse clear_ir_line[irq_id] for exactly one cycle, clear int_out, and go to ACK1.
REQ-021 PENDING with eligible==0 at the INTA fall (spurious) SHALL latch irq_id=7, set no ISR bit, issue no clear pulse, and mark the acknowledge as spurious.
REQ-022 ACK1: on an INTA fall SHALL register vector_out={vector_base, irq_id[2:0]}, set vector_oe=1, and go to ACK2.
REQ-023 ACK2: on an INTA rise SHALL clear vector_oe; if auto_eoi=1 and the acknowledge was not spurious, SHALL clear in_service_reg[irq_id]; SHALL then go to IDLE.
REQ-024 An INTA fall in IDLE, or an INTA rise in PENDING or ACK1, SHALL be ignored.
REQ-025 eoi_cmd SHALL clear the lowest-index set ISR bit, in any state; with no ISR bit set it SHALL do nothing.
REQ-026 If eoi_cmd and the auto-EOI clear hit the same bit in the same cycle, SHALL clear only that bit, once.
REQ-027 If eoi_cmd coincides with an ISR set in PENDING, the EOI SHALL act on the ISR value before the set; the set SHALL still take effect.
REQ-028 clear_ir_line SHALL be zero in every cycle other than the REQ-020 pulse.
REQ-029 A new request SHALL be evaluated no earlier than the first IDLE cycle after ACK2.

Reset
REQ-030 On reset_n=0, SHALL immediately force state=IDLE, int_out=0, clear_ir_line=0, in_service_reg=0, vector_out=0, vector_oe=0, irq_id=0, spurious=0, inta_n_d=1.
REQ-031 Reset asserted mid-acknowledge SHALL abandon the cycle with no clear pulse emitted; after release, operation SHALL restart from IDLE.

Structure
REQ-032 The state encoding constants and the IR count (8) SHALL live in the shared 8259 package used by the control logic.
REQ-033 The priority resolver SHALL be the sub-module priority_resolver_8: input 8-bit eligible; outputs 3-bit id and a valid bit.

Verification
REQ-034 Bench SHALL drive irr=8'h20 (mask 0, base 5'h08), then two INTA pulses: int_out rises; one clear_ir_line=8'h20 pulse at INTA#1; in_service_reg=8'h20; vector_out=8'h45 with vector_oe high during INTA#2.
REQ-035 Bench SHALL drive irr=8'h0A: winner IR1 with vector {base,3'd1}; then eoi_cmd; then IR3 is serviced.
REQ-036 Bench SHALL set ISR=8'h04 and drive irr=8'h10: int_out stays 0; after eoi_cmd, int_out rises.
REQ-037 Bench SHALL raise irr=8'h01, drop it before INTA#1: spurious vector {base,3'd7}, ISR unchanged, clear_ir_line stays 0.
REQ-038 Bench SHALL run with auto_eoi=1: ISR returns to 0 on the INTA#2 rise.
REQ-039 Bench SHALL assert reset_n low in ACK1: all outputs reach reset values asynchronously, and the state is IDLE after release.
